// File: rtl/mem_responder.sv
// mem_responder: target end of the CPU's one-hot mem_cmd bus.
//   Holds a 256x16 RAM at 0x000-0x0FF, a write-only LED register, a read-only
//   switch port, and a stream loader that fills RAM from address 0 while the
//   CPU is held off (busy).
// Ports:
//   clk, reset          clock, async active-high reset
//   mem_addr/mem_cmd    CPU address and one-hot command (001 none, 010 read, 100 write)
//   write_data          CPU store data
//   read_data           registered read data, valid the cycle after MREAD
//   sw / led            board switches in, LED register out
//   ld_start/ld_valid/ld_data/ld_last/ld_ready   loader stream handshake
//   busy / ld_done      load in progress / load finished
//   cmd_err             sticky illegal-command flag
module mem_responder #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 9,
    parameter int                RAM_WORDS = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_cmd,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic [7:0]        sw,
    output logic [7:0]        led,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              ld_done,
    output logic              cmd_err
);
    localparam int              PTR_W    = $clog2(RAM_WORDS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAM_WORDS - 1);

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]  read_data_q, read_data_d;
    logic [7:0]         led_q, led_d;
    logic               cmd_err_q, cmd_err_d;

    logic [DATA_W-1:0]  mem [RAM_WORDS];

    // ---------------- loader FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ld_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    // A full image ends at the top word even without ld_last.
                    if (ld_last || ptr_q == LAST_PTR)
                        state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready = (state_q == S_LOAD);
        busy     = (state_q == S_LOAD);
        ld_done  = (state_q == S_DONE);
    end

    // ---------------- CPU command decode ----------------
    logic cmd_rd, cmd_wr, cmd_bad;
    always_comb begin
        cmd_rd  = 1'b0;
        cmd_wr  = 1'b0;
        cmd_bad = 1'b0;
        // case matches exactly, so X/Z-bearing commands land in default.
        case (mem_cmd)
            MNONE:   ;
            MREAD:   cmd_rd = 1'b1;
            MWRITE:  cmd_wr = 1'b1;
            default: cmd_bad = 1'b1;
        endcase
    end

    logic             is_ram;
    logic [PTR_W-1:0] ram_idx;
    logic [DATA_W-1:0] rd_sel;
    assign is_ram  = ~mem_addr[ADDR_W-1];
    assign ram_idx = mem_addr[PTR_W-1:0];

    always_comb begin
        rd_sel = '0;
        if (is_ram)
            rd_sel = mem[ram_idx];
        else if (mem_addr == SW_ADDR)
            rd_sel = {{(DATA_W-8){1'b0}}, sw};
    end

    // CPU side is fully gated while the loader owns the RAM.
    logic cpu_rd, cpu_wr;
    assign cpu_rd = cmd_rd & ~busy;
    assign cpu_wr = cmd_wr & ~busy;

    always_comb begin
        read_data_d = read_data_q;
        led_d       = led_q;
        cmd_err_d   = cmd_err_q;
        if (cpu_rd)
            read_data_d = rd_sel;
        if (cpu_wr && mem_addr == LED_ADDR)
            led_d = write_data[7:0];
        if (cmd_bad && !busy)
            cmd_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
            led_q       <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            led_q       <= led_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // ---------------- RAM write port ----------------
    // Loader and CPU are mutually exclusive through busy, so one port suffices.
    logic              ld_acc, ram_we;
    logic [PTR_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    assign ld_acc    = ld_valid & ld_ready;
    assign ram_we    = ld_acc | (cpu_wr & is_ram);
    assign ram_waddr = ld_acc ? ptr_q : ram_idx;
    assign ram_wdata = ld_acc ? ld_data : write_data;

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
    end

    assign read_data = read_data_q;
    assign led       = led_q;
    assign cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: read expectations are queued by the
// driver and popped by an independent monitor one cycle after each MREAD.
module tb_mem_responder;
    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  mem_addr = '0;
    logic [2:0]  mem_cmd = MNONE;
    logic [15:0] write_data = '0;
    logic [15:0] read_data;
    logic [7:0]  sw = '0;
    logic [7:0]  led;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_ready, busy, ld_done, cmd_err;

    mem_responder dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
        .write_data(write_data), .read_data(read_data), .sw(sw), .led(led),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .busy(busy),
        .ld_done(ld_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [8:0] a; logic [15:0] d; } exp_t;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   sb_chk = 1'b0;
    bit   pend = 1'b0;
    logic [8:0] sb_addr = '0;

    // Monitor: a checked command seen at an edge is compared at the next negedge.
    always @(posedge clk) pend <= sb_chk;
    always @(negedge clk) begin
        if (pend) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_underflow: read_data=%h with no expected entry", read_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (read_data !== e.d) begin
                    n_fail++;
                    $display("FAIL rd@%h: got %h expected %h", e.a, read_data, e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one command for one clock; returns #1 after the edge.
    task automatic drive(input logic [2:0] c, input logic [8:0] a, input logic [15:0] wd,
                         input bit check, input logic [15:0] exp);
        exp_t e;
        mem_cmd = c; mem_addr = a; write_data = wd; sb_chk = check;
        if (check) begin
            e.a = a; e.d = exp;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        sb_chk = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        #12;
        chk("rst_read_data", read_data, 16'h0);
        chk("rst_led", {8'h0, led}, 16'h0);
        chk("rst_ld_ready", {15'h0, ld_ready}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_ld_done", {15'h0, ld_done}, 16'h0);
        chk("rst_cmd_err", {15'h0, cmd_err}, 16'h0);
        reset = 1'b0;
        tick();

        // ---- 3-word load ----
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        chk("ld3_busy", {15'h0, busy}, 16'h1);
        ld_valid = 1'b1; ld_data = 16'hD107; ld_last = 1'b0;
        chk("ld3_ready0", {15'h0, ld_ready}, 16'h1); tick();
        ld_data = 16'hE000;
        chk("ld3_ready1", {15'h0, ld_ready}, 16'h1); tick();
        ld_data = 16'h1234; ld_last = 1'b1;
        chk("ld3_ready2", {15'h0, ld_ready}, 16'h1); tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("ld3_done", {15'h0, ld_done}, 16'h1);
        chk("ld3_busy_off", {15'h0, busy}, 16'h0);
        chk("ld3_ready_off", {15'h0, ld_ready}, 16'h0);
        drive(MREAD, 9'h000, 16'h0, 1, 16'hD107);
        drive(MREAD, 9'h001, 16'h0, 1, 16'hE000);
        drive(MREAD, 9'h002, 16'h0, 1, 16'h1234);

        // ---- RAM write / read / hold ----
        drive(MWRITE, 9'h005, 16'hBEEF, 0, 16'h0);
        drive(MREAD,  9'h005, 16'h0, 1, 16'hBEEF);
        for (int i = 0; i < 3; i++) drive(MNONE, 9'h000, 16'h0, 1, 16'hBEEF);

        // ---- I/O decode ----
        sw = 8'hA5;
        drive(MREAD,  9'h140, 16'h0, 1, 16'h00A5);
        drive(MWRITE, 9'h100, 16'h3C5A, 0, 16'h0);
        chk("led_write", {8'h0, led}, 16'h005A);
        drive(MREAD,  9'h100, 16'h0, 1, 16'h0000);
        drive(MWRITE, 9'h0FF, 16'h1111, 0, 16'h0);
        drive(MREAD,  9'h1FF, 16'h0, 1, 16'h0000);
        drive(MWRITE, 9'h1FF, 16'hFFFF, 0, 16'h0);
        chk("led_unmapped_wr", {8'h0, led}, 16'h005A);
        drive(MREAD,  9'h0FF, 16'h0, 1, 16'h1111);
        drive(MREAD,  9'h005, 16'h0, 1, 16'hBEEF);

        // ---- illegal command ----
        drive(3'b011, 9'h000, 16'hDEAD, 1, 16'hBEEF);
        chk("cmd_err_set", {15'h0, cmd_err}, 16'h1);
        drive(MREAD,  9'h000, 16'h0, 1, 16'hD107);
        drive(MNONE,  9'h000, 16'h0, 0, 16'h0);
        chk("cmd_err_sticky", {15'h0, cmd_err}, 16'h1);

        // ---- full 256-word load, no ld_last ----
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_data = 16'hA000 + 16'(i);
            if (i == 255) chk("full_ready_255", {15'h0, ld_ready}, 16'h1);
            tick();
        end
        chk("full_done", {15'h0, ld_done}, 16'h1);
        ld_data = 16'hFFFF; tick();  // extra word must be ignored in DONE
        ld_valid = 1'b0;
        chk("full_ready_off", {15'h0, ld_ready}, 16'h0);
        drive(MREAD, 9'h000, 16'h0, 1, 16'hA000);
        drive(MREAD, 9'h080, 16'h0, 1, 16'hA080);
        drive(MREAD, 9'h0FF, 16'h0, 1, 16'hA0FF);

        // ---- reset mid-load, busy gating ----
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data = 16'h5550; mem_cmd = MWRITE; mem_addr = 9'h100; write_data = 16'h00C3; tick();
        ld_data = 16'h5551; mem_addr = 9'h007; write_data = 16'h7777; tick();
        mem_cmd = MNONE;
        chk("busy_led_hold", {8'h0, led}, 16'h005A);
        chk("busy_mid", {15'h0, busy}, 16'h1);
        ld_data = 16'h5552;
        reset = 1'b1; #1;
        chk("async_busy", {15'h0, busy}, 16'h0);
        chk("async_ready", {15'h0, ld_ready}, 16'h0);
        chk("async_cmd_err", {15'h0, cmd_err}, 16'h0);
        #1; reset = 1'b0; ld_valid = 1'b0;
        tick();
        drive(MREAD, 9'h000, 16'h0, 1, 16'h5550);
        drive(MREAD, 9'h001, 16'h0, 1, 16'h5551);
        drive(MREAD, 9'h002, 16'h0, 1, 16'hA002);
        drive(MREAD, 9'h007, 16'h0, 1, 16'hA007);
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 16'h6660; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("reload_done", {15'h0, ld_done}, 16'h1);
        drive(MREAD, 9'h000, 16'h0, 1, 16'h6660);
        drive(MREAD, 9'h001, 16'h0, 1, 16'h5551);
        drive(MNONE, 9'h000, 16'h0, 0, 16'h0);
        tick();
        chk("sb_drained", 16'(exp_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
